// File: rtl/modem_hdlc_rx_if.sv
// modem_hdlc_rx_if -- bundle of the HDLC receiver line-side and byte-side signals.
//   bit_i, bit_valid_i : serial line bit and its one-cycle strobe (driven by the master)
//   byte_o             : last emitted payload byte
//   begin_o, valid_o   : first-byte marker and per-byte strobe
//   end_o, crc_ok_o    : normal frame close and its FCS verdict
//   abort_o            : abnormal termination of a begun frame
//   clk_req_o          : receiver is inside a frame (DATA state)
interface modem_hdlc_rx_if;
    logic       bit_i;
    logic       bit_valid_i;
    logic [7:0] byte_o;
    logic       begin_o;
    logic       valid_o;
    logic       end_o;
    logic       crc_ok_o;
    logic       abort_o;
    logic       clk_req_o;

    modport master (
        output bit_i, bit_valid_i,
        input  byte_o, begin_o, valid_o, end_o, crc_ok_o, abort_o, clk_req_o
    );

    modport slave (
        input  bit_i, bit_valid_i,
        output byte_o, begin_o, valid_o, end_o, crc_ok_o, abort_o, clk_req_o
    );
endinterface

// File: rtl/modem_hdlc_rx.sv
// modem_hdlc_rx -- bit-serial HDLC receiver: flag hunting, zero-bit destuffing,
// byte assembly, CRC-16/X.25 checking and FCS stripping through a two-byte delay line.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, dominates a same-cycle bit strobe
//   bus_if : modem_hdlc_rx_if.slave (line bit in, payload bytes and frame events out)
// Parameter CHECK_FCS = 0 reports every normally closed frame as crc_ok.
module modem_hdlc_rx #(
    parameter bit CHECK_FCS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    modem_hdlc_rx_if.slave bus_if
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // One byte through the reflected X.25 polynomial, LSB first.
    function automatic logic [15:0] crc16_x25_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      r_state;
    logic [2:0]  r_ones;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shreg;
    logic [1:0]  r_held;
    logic [7:0]  r_h0;
    logic [7:0]  r_h1;
    logic [15:0] r_crc;
    logic        r_begun;
    logic [7:0]  r_byte;
    logic        r_begin;
    logic        r_valid;
    logic        r_end;
    logic        r_crc_ok;
    logic        r_abort;
    logic        r_clk_req;

    logic        w_seventh;
    logic        w_flag;
    logic        w_stuff;
    logic        w_shift;
    logic        w_done;
    logic [7:0]  w_byte;
    logic [15:0] w_crc_next;
    logic [2:0]  w_ones_inc;

    // Classification of the bit being sampled, based on the run of 1s before it.
    assign w_seventh  = bus_if.bit_i & (r_ones == 3'd6);
    assign w_flag     = ~bus_if.bit_i & (r_ones == 3'd6);
    assign w_stuff    = ~bus_if.bit_i & (r_ones == 3'd5);
    assign w_shift    = ~(w_seventh | w_flag | w_stuff);
    assign w_done     = w_shift & (r_bit_cnt == 3'd7);
    assign w_byte     = {bus_if.bit_i, r_shreg[7:1]};
    assign w_crc_next = crc16_x25_byte(r_crc, w_byte);
    assign w_ones_inc = (r_ones == 3'd7) ? 3'd7 : (r_ones + 3'd1);

    assign bus_if.byte_o    = r_byte;
    assign bus_if.begin_o   = r_begin;
    assign bus_if.valid_o   = r_valid;
    assign bus_if.end_o     = r_end;
    assign bus_if.crc_ok_o  = r_crc_ok;
    assign bus_if.abort_o   = r_abort;
    assign bus_if.clk_req_o = r_clk_req;

    // Receiver FSM, byte assembler, CRC and FCS-stripping delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HUNT;
            r_ones    <= 3'd0;
            r_bit_cnt <= 3'd0;
            r_shreg   <= 8'h00;
            r_held    <= 2'd0;
            r_h0      <= 8'h00;
            r_h1      <= 8'h00;
            r_crc     <= 16'hFFFF;
            r_begun   <= 1'b0;
            r_byte    <= 8'h00;
            r_begin   <= 1'b0;
            r_valid   <= 1'b0;
            r_end     <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_abort   <= 1'b0;
            r_clk_req <= 1'b0;
        end else begin
            r_begin  <= 1'b0;
            r_valid  <= 1'b0;
            r_end    <= 1'b0;
            r_crc_ok <= 1'b0;
            r_abort  <= 1'b0;
            if (bus_if.bit_valid_i) begin
                r_ones <= bus_if.bit_i ? w_ones_inc : 3'd0;
                if (w_seventh) begin
                    // Abort sequence: only a frame that already showed payload reports it.
                    if ((r_state == ST_DATA) && r_begun) begin
                        r_abort <= 1'b1;
                    end
                    r_state   <= ST_HUNT;
                    r_clk_req <= 1'b0;
                    r_begun   <= 1'b0;
                end else if (w_flag) begin
                    // The flag's own 0+six 1s were shifted in, so an aligned close sits at bit_cnt 7.
                    // r_begun implies at least three completed bytes in this frame.
                    if (r_state == ST_DATA) begin
                        if (r_bit_cnt == 3'd7) begin
                            if (r_begun) begin
                                r_end    <= 1'b1;
                                r_crc_ok <= (r_crc == 16'hF0B8) | ~CHECK_FCS;
                            end
                        end else if (r_begun) begin
                            r_abort <= 1'b1;
                        end
                    end
                    // Every flag also opens the next frame.
                    r_state   <= ST_SYNC;
                    r_clk_req <= 1'b0;
                    r_bit_cnt <= 3'd0;
                    r_held    <= 2'd0;
                    r_crc     <= 16'hFFFF;
                    r_begun   <= 1'b0;
                end else if (w_shift) begin
                    r_shreg   <= w_byte;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_done && (r_state != ST_HUNT)) begin
                        r_state   <= ST_DATA;
                        r_clk_req <= 1'b1;
                        r_crc     <= w_crc_next;
                        // The last two bytes before the closing flag are the FCS and never leave.
                        case (r_held)
                            2'd0: begin
                                r_h0   <= w_byte;
                                r_held <= 2'd1;
                            end
                            2'd1: begin
                                r_h1   <= w_byte;
                                r_held <= 2'd2;
                            end
                            default: begin
                                r_byte  <= r_h0;
                                r_valid <= 1'b1;
                                r_begin <= ~r_begun;
                                r_begun <= 1'b1;
                                r_h0    <= r_h1;
                                r_h1    <= w_byte;
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/modem_hdlc_rx.md
MODEM_HDLC_RX -- requirements
Module: modem_hdlc_rx

Interface
REQ-001 Parameter: CHECK_FCS, default 1; 0 forces crc_ok_o to 1 at every end_o (FCS bytes still stripped).
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bit_i  input  1  line bit, LSB-first per byte; sampled only when bit_valid_i=1.
REQ-005 bit_valid_i  input  1  one-cycle strobe per line bit, minimum spacing 2 clk.
REQ-006 byte_o  output  8  received payload byte, meaningful when valid_o=1.
REQ-007 begin_o  output  1  one-cycle pulse marking the first payload byte of a frame.
REQ-008 valid_o  output  1  one-cycle pulse per payload byte; no backpressure.
REQ-009 end_o  output  1  one-cycle pulse, frame closed normally.
REQ-010 crc_ok_o  output  1  FCS result, valid only while end_o=1, else 0.
REQ-011 abort_o  output  1  one-cycle pulse, begun frame terminated abnormally.
REQ-012 clk_req_o  output  1  high while state is DATA.

Function
REQ-013 States: HUNT, SYNC, DATA; reset state HUNT.
REQ-014 ones_cnt (3 bit, saturating at 7): increments on each sampled 1; clears on each sampled 0.
REQ-015 Sampled 0 with ones_cnt==5 is a stuffed bit; discarded, no data-bit count.
REQ-016 Sampled 0 with ones_cnt==6 is a flag; otherwise every non-stuffed bit shifts into the byte assembler and increments bit_cnt (3 bit, wraps 7->0).
REQ-017 bit_cnt wrapping 7->0 completes a byte; completed bytes count only in SYNC/DATA.
REQ-018 Flag in HUNT: go SYNC, bit_cnt<=0, held<=0, CRC<=0xFFFF.
REQ-019 SYNC: first completed byte -> DATA; back-to-back flags keep SYNC.
REQ-020 Flag in DATA with bit_cnt==7 (aligned) and frame bytes >=3: end_o=1, crc_ok_o=(CRC==0xF0B8)|~CHECK_FCS; go SYNC, re-init as REQ-018 (closing flag is shared opening flag).
REQ-021 Flag in DATA, aligned, frame bytes <=2: frame discarded silently, no pulses; go SYNC.
REQ-022 Flag in DATA with bit_cnt!=7 (misaligned): abort_o=1 if begin_o was issued this frame, else silent; go SYNC.
REQ-023 Seventh consecutive 1 (ones_cnt 6->7): in DATA abort as REQ-022 rule, all states go HUNT.
REQ-024 CRC-16/X.25 (reflected poly 0x8408, init 0xFFFF) updated bytewise on each completed byte, FCS bytes included.
REQ-025 Two-byte delay line (held 0..2) strips FCS: on a completed byte with held==2, oldest byte is emitted on byte_o with valid_o=1; begin_o=1 with the first emitted byte of the frame.
REQ-026 Output latency: valid_o/end_o/abort_o asserted exactly 1 clk after the bit_valid_i cycle that causes them.
REQ-027 end_o and abort_o never both asserted; at most one of them per begun frame.
REQ-028 All outputs registered; byte_o holds last emitted value between pulses.

Reset
REQ-029 rst dominates bit_valid_i in the same cycle.
REQ-030 On rst: state HUNT, ones_cnt/bit_cnt/held=0, CRC=0xFFFF, byte_o=0x00, all pulse outputs and clk_req_o =0.
REQ-031 Reset mid-frame emits no end_o/abort_o; next frame requires a new opening flag.

Verification
REQ-032 Idle 1s, 7E, "123456789", 6E 90, 7E -> begin_o with 0x31, nine valid_o 0x31..0x39, end_o with crc_ok_o=1, state SYNC.
REQ-033 7E, FF 7E payload + correct FCS, 7E with stuffing -> valid_o 0xFF then 0x7E, no false flag, crc_ok_o=1.
REQ-034 7E, four bytes, then eight 1s -> abort_o 1 clk after 7th 1, no end_o, HUNT; subsequent valid frame received normally.
REQ-035 7E 12 34 7E -> no begin_o/valid_o/end_o/abort_o; 7E 7E 7E -> no pulses, stays SYNC.
REQ-036 Frame of REQ-032 with one payload bit flipped -> nine valid_o, end_o with crc_ok_o=0; same with CHECK_FCS=0 -> crc_ok_o=1.
REQ-037 rst asserted after third payload byte -> all outputs 0 next clk, no end_o; 3-bit misaligned close flag -> abort_o.
